// File: rtl/id_pipe_pkg.sv
// Shared opcode/funct constants, ALU operation encodings and the output-register payload
// type for the id_pipe decode stage.
package id_pipe_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam int ALU_W = 4;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // wd is kept at full 5 bits; the top truncates to REG_AW on the way out
    typedef struct packed {
        logic [31:0]      inst_addr;
        logic [31:0]      inst;
        logic [31:0]      op1;
        logic [31:0]      op2;
        logic [ALU_W-1:0] alu_op;
        logic [4:0]       wd;
        logic             wen;
        logic             illegal;
    } pay_t;

    function automatic logic reg_ok(input logic [4:0] f, input int aw);
        return int'(f) < (1 << aw);
    endfunction

endpackage

// File: rtl/id_dec.sv
// Combinational decoder for RV32I/RV32E OP-IMM, OP, LUI and AUIPC: register usage,
// operands, ALU operation, destination and legality.
module id_dec
    import id_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       inst_i,
    input  logic [31:0]       inst_addr_i,
    input  logic [31:0]       rs1_data_i,
    input  logic [31:0]       rs2_data_i,
    output logic              rs1_use_o,
    output logic              rs2_use_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic [31:0]       op1_o,
    output logic [31:0]       op2_o,
    output logic [ALU_W-1:0]  alu_op_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wen_o,
    output logic              illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic        fmt_ok;
    logic        regs_ok;
    logic [31:0] op1;
    logic [31:0] op2;
    alu_op_e     alu;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign rd_f   = inst_i[11:7];
    assign rs1_f  = inst_i[19:15];
    assign rs2_f  = inst_i[24:20];

    always_comb begin
        rs1_use_o = 1'b0;
        rs2_use_o = 1'b0;
        op1       = '0;
        op2       = '0;
        alu       = ALU_ADD;
        fmt_ok    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                rs1_use_o = 1'b1;
                op1       = rs1_data_i;
                op2       = {{20{inst_i[31]}}, inst_i[31:20]};
                fmt_ok    = 1'b1;
                case (f3)
                    F3_ADD:  alu = ALU_ADD;
                    F3_SLT:  alu = ALU_SLT;
                    F3_SLTU: alu = ALU_SLTU;
                    F3_XOR:  alu = ALU_XOR;
                    F3_OR:   alu = ALU_OR;
                    F3_SLL: begin
                        alu    = ALU_SLL;
                        op2    = {27'b0, inst_i[24:20]};
                        fmt_ok = (f7 == F7_BASE);
                    end
                    F3_SR: begin
                        alu    = f7[5] ? ALU_SRA : ALU_SRL;
                        op2    = {27'b0, inst_i[24:20]};
                        fmt_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                    default: alu = ALU_AND;
                endcase
            end
            OPC_OP: begin
                rs1_use_o = 1'b1;
                rs2_use_o = 1'b1;
                op1       = rs1_data_i;
                op2       = rs2_data_i;
                fmt_ok    = (f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                case (f3)
                    F3_ADD:  alu = f7[5] ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu = ALU_SLL;
                    F3_SLT:  alu = ALU_SLT;
                    F3_SLTU: alu = ALU_SLTU;
                    F3_XOR:  alu = ALU_XOR;
                    F3_SR:   alu = f7[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu = ALU_OR;
                    default: alu = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                op2    = {inst_i[31:12], 12'b0};
                fmt_ok = 1'b1;
            end
            OPC_AUIPC: begin
                op1    = inst_addr_i;
                op2    = {inst_i[31:12], 12'b0};
                fmt_ok = 1'b1;
            end
            default: fmt_ok = 1'b0;
        endcase
    end

    // RV32E: any referenced register at or above 2**REG_AW makes the instruction illegal
    assign regs_ok = reg_ok(rd_f, REG_AW) &&
                     (!rs1_use_o || reg_ok(rs1_f, REG_AW)) &&
                     (!rs2_use_o || reg_ok(rs2_f, REG_AW));

    assign illegal_o  = !(fmt_ok && regs_ok);
    assign op1_o      = illegal_o ? 32'b0 : op1;
    assign op2_o      = illegal_o ? 32'b0 : op2;
    assign alu_op_o   = illegal_o ? ALU_ADD : alu;
    assign wd_o       = illegal_o ? '0 : rd_f[REG_AW-1:0];
    assign wen_o      = !illegal_o && (rd_f != 5'd0);
    assign rs1_addr_o = rs1_use_o ? inst_i[15 +: REG_AW] : '0;
    assign rs2_addr_o = rs2_use_o ? inst_i[20 +: REG_AW] : '0;

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: load-use interlock, valid/ready output register, flush and a
// saturating stall counter around the id_dec decoder.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int ALU_OP_W    = 4,
    parameter int STALL_CNT_W = 16,
    parameter bit ZERO_IDLE   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [31:0]            inst_addr_i,
    input  logic [31:0]            inst_i,
    output logic [REG_AW-1:0]      rs1_addr_o,
    output logic [REG_AW-1:0]      rs2_addr_o,
    input  logic [31:0]            rs1_data_i,
    input  logic [31:0]            rs2_data_i,
    input  logic [REG_AW-1:0]      ex_wd_addr_i,
    input  logic                   ex_reg_wen_i,
    input  logic                   ex_is_load_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            inst_addr_o,
    output logic [31:0]            inst_o,
    output logic [31:0]            op_1_o,
    output logic [31:0]            op_2_o,
    output logic [ALU_OP_W-1:0]    alu_op_o,
    output logic [REG_AW-1:0]      wd_addr_o,
    output logic                   reg_wen_o,
    output logic                   illegal_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    logic                   rs1_use;
    logic                   rs2_use;
    logic [31:0]            dec_op1;
    logic [31:0]            dec_op2;
    logic [ALU_W-1:0]       dec_alu;
    logic [REG_AW-1:0]      dec_wd;
    logic                   dec_wen;
    logic                   dec_ill;
    logic                   hazard;
    logic                   accept;

    logic                   valid_d,     valid_q;
    pay_t                   pay_d,       pay_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    id_dec #(.REG_AW(REG_AW)) u_dec (
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .rs1_use_o   (rs1_use),
        .rs2_use_o   (rs2_use),
        .rs1_addr_o  (rs1_addr_o),
        .rs2_addr_o  (rs2_addr_o),
        .op1_o       (dec_op1),
        .op2_o       (dec_op2),
        .alu_op_o    (dec_alu),
        .wd_o        (dec_wd),
        .wen_o       (dec_wen),
        .illegal_o   (dec_ill)
    );

    // A load in EX has no result yet; hold any consumer of its destination
    assign hazard = ex_is_load_i && ex_reg_wen_i && (ex_wd_addr_i != '0) &&
                    ((rs1_use && (rs1_addr_o == ex_wd_addr_i)) ||
                     (rs2_use && (rs2_addr_o == ex_wd_addr_i)));

    assign in_ready_o = !flush_i && !hazard && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        valid_d     = valid_q;
        pay_d       = pay_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d         = 1'b1;
            pay_d.inst_addr = inst_addr_i;
            pay_d.inst      = inst_i;
            pay_d.op1       = dec_op1;
            pay_d.op2       = dec_op2;
            pay_d.alu_op    = dec_alu;
            pay_d.wd        = 5'(dec_wd);
            pay_d.wen       = dec_wen;
            pay_d.illegal   = dec_ill;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
        if (ZERO_IDLE && !valid_d) begin
            pay_d = '0;
        end
        if (in_valid_i && hazard && !flush_i && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pay_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pay_q       <= pay_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o = valid_q;
    assign inst_addr_o = pay_q.inst_addr;
    assign inst_o      = pay_q.inst;
    assign op_1_o      = pay_q.op1;
    assign op_2_o      = pay_q.op2;
    assign alu_op_o    = ALU_OP_W'(pay_q.alu_op);
    assign wd_addr_o   = pay_q.wd[REG_AW-1:0];
    assign reg_wen_o   = pay_q.wen;
    assign illegal_o   = pay_q.illegal;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: a behavioural RV32I decode/handshake model checked every cycle, plus
// directed literal checks; a second RV32E instance covers register limits and saturation.
module tb_id_pipe;
    import id_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, flush;
    logic [31:0] inst, pc, rs1_data, rs2_data;
    logic [4:0]  ex_wd;
    logic        ex_wen, ex_load;

    logic        in_ready, out_valid, reg_wen, illegal;
    logic [4:0]  rs1_addr, rs2_addr, wd_addr;
    logic [31:0] inst_addr_o, inst_o, op_1, op_2;
    logic [3:0]  alu_op;
    logic [15:0] stall_cnt;

    logic        e_in_ready, e_out_valid, e_reg_wen, e_illegal;
    logic [3:0]  e_rs1_addr, e_rs2_addr, e_wd_addr, e_alu_op;
    logic [31:0] e_inst_addr, e_inst, e_op_1, e_op_2;
    logic [1:0]  e_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_pipe dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_addr_i(pc), .inst_i(inst), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .ex_wd_addr_i(ex_wd),
        .ex_reg_wen_i(ex_wen), .ex_is_load_i(ex_load), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .inst_addr_o(inst_addr_o),
        .inst_o(inst_o), .op_1_o(op_1), .op_2_o(op_2), .alu_op_o(alu_op),
        .wd_addr_o(wd_addr), .reg_wen_o(reg_wen), .illegal_o(illegal), .stall_cnt_o(stall_cnt)
    );

    id_pipe #(.REG_AW(4), .ALU_OP_W(4), .STALL_CNT_W(2), .ZERO_IDLE(1'b0)) dut_e (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(e_in_ready),
        .inst_addr_i(pc), .inst_i(inst), .rs1_addr_o(e_rs1_addr), .rs2_addr_o(e_rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .ex_wd_addr_i(ex_wd[3:0]),
        .ex_reg_wen_i(ex_wen), .ex_is_load_i(ex_load), .flush_i(flush),
        .out_valid_o(e_out_valid), .out_ready_i(out_ready), .inst_addr_o(e_inst_addr),
        .inst_o(e_inst), .op_1_o(e_op_1), .op_2_o(e_op_2), .alu_op_o(e_alu_op),
        .wd_addr_o(e_wd_addr), .reg_wen_o(e_reg_wen), .illegal_o(e_illegal),
        .stall_cnt_o(e_stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (RV32I, ZERO_IDLE=1) ----------------
    typedef struct packed {
        logic        r1u, r2u;
        logic [31:0] pc, inst, op1, op2;
        logic [3:0]  alu;
        logic [4:0]  wd;
        logic        wen, ill;
    } mdl_t;

    function automatic mdl_t mdec(input logic [31:0] w, input logic [31:0] a_pc,
                                  input logic [31:0] a, input logic [31:0] b);
        mdl_t d;
        logic ok;
        logic [3:0] tab [8];
        logic [2:0] f3;
        logic [6:0] f7;
        tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        f3 = w[14:12];
        f7 = w[31:25];
        d = '0;
        d.pc = a_pc;
        d.inst = w;
        ok = 1'b0;
        if (w[6:0] == 7'h13) begin
            d.r1u = 1'b1; d.op1 = a; ok = 1'b1; d.alu = tab[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                d.op2 = 32'(w[24:20]);
                ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                if (f3 == 3'd5 && f7 == 7'h20) d.alu = ALU_SRA;
            end else begin
                d.op2 = 32'($signed(w[31:20]));
            end
        end else if (w[6:0] == 7'h33) begin
            d.r1u = 1'b1; d.r2u = 1'b1; d.op1 = a; d.op2 = b; d.alu = tab[f3];
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (f7 == 7'h20) d.alu = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
        end else if (w[6:0] == 7'h37) begin
            d.op2 = w & 32'hFFFF_F000; d.alu = ALU_ADD; ok = 1'b1;
        end else if (w[6:0] == 7'h17) begin
            d.op1 = a_pc; d.op2 = w & 32'hFFFF_F000; d.alu = ALU_ADD; ok = 1'b1;
        end
        if (ok) begin
            d.wd = w[11:7];
            d.wen = (w[11:7] != 0);
        end else begin
            d.op1 = 0; d.op2 = 0; d.alu = ALU_ADD; d.ill = 1'b1;
        end
        return d;
    endfunction

    mdl_t        cur, m_p;
    logic        m_vld, m_live = 1'b0, m_hz, m_rdy;
    logic [15:0] m_cnt;

    always_comb begin
        cur   = mdec(inst, pc, rs1_data, rs2_data);
        m_hz  = ex_load && ex_wen && ex_wd != 0 &&
                ((cur.r1u && inst[19:15] == ex_wd) || (cur.r2u && inst[24:20] == ex_wd));
        m_rdy = !flush && !m_hz && (!m_vld || out_ready);
    end

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (rst) begin
            m_vld <= 1'b0; m_p <= '0; m_cnt <= 16'd0;
        end else begin
            if (flush) begin
                m_vld <= 1'b0; m_p <= '0;
            end else if (in_valid && m_rdy) begin
                m_vld <= 1'b1; m_p <= cur;
            end else if (out_ready) begin
                m_vld <= 1'b0; m_p <= '0;
            end
            if (in_valid && m_hz && !flush && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready",  32'(in_ready),  32'(m_rdy));
            chk("rs1_addr",  32'(rs1_addr),  cur.r1u ? 32'(inst[19:15]) : 32'd0);
            chk("rs2_addr",  32'(rs2_addr),  cur.r2u ? 32'(inst[24:20]) : 32'd0);
            chk("out_valid", 32'(out_valid), 32'(m_vld));
            chk("inst_addr", inst_addr_o,    m_p.pc);
            chk("inst",      inst_o,         m_p.inst);
            chk("op_1",      op_1,           m_p.op1);
            chk("op_2",      op_2,           m_p.op2);
            chk("alu_op",    32'(alu_op),    32'(m_p.alu));
            chk("wd_addr",   32'(wd_addr),   32'(m_p.wd));
            chk("reg_wen",   32'(reg_wen),   32'(m_p.wen));
            chk("illegal",   32'(illegal),   32'(m_p.ill));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        inst = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        ex_wd = 5'd0; ex_wen = 1'b0; ex_load = 1'b0;
        cyc(); cyc();
        mid();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_op2",   op_2,           32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        cyc();
        rst = 1'b0;

        // 1: addi x1,x0,5
        in_valid = 1'b1; inst = 32'h0050_0093; pc = 32'h100;
        cyc(); in_valid = 1'b0;
        mid();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_op2",   op_2,           32'd5);
        chk("t1_wd",    32'(wd_addr),   32'd1);
        chk("t1_wen",   32'(reg_wen),   32'd1);
        chk("t1_alu",   32'(alu_op),    32'(ALU_ADD));

        // 2: sub x3,x1,x2
        cyc();
        in_valid = 1'b1; inst = 32'h4020_81B3; pc = 32'h104; rs1_data = 32'd9; rs2_data = 32'd4;
        mid();
        chk("t2_rs1", 32'(rs1_addr), 32'd1);
        chk("t2_rs2", 32'(rs2_addr), 32'd2);
        cyc(); in_valid = 1'b0;
        mid();
        chk("t2_op1", op_1,         32'd9);
        chk("t2_op2", op_2,         32'd4);
        chk("t2_alu", 32'(alu_op),  32'(ALU_SUB));

        // 3: load-use stall on x1 for three cycles
        cyc();
        ex_load = 1'b1; ex_wen = 1'b1; ex_wd = 5'd1;
        in_valid = 1'b1; inst = 32'h0020_81B3; pc = 32'h108;
        mid();
        chk("t3_ready", 32'(in_ready), 32'd0);
        cyc(); cyc(); cyc();
        ex_load = 1'b0;
        mid();
        chk("t3_stall",   32'(stall_cnt),   32'd3);
        chk("t3_e_stall", 32'(e_stall_cnt), 32'd3);
        chk("t3_ready1",  32'(in_ready),    32'd1);
        cyc(); in_valid = 1'b0;
        mid();
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_alu",   32'(alu_op),    32'(ALU_ADD));
        chk("t3_wd",    32'(wd_addr),   32'd3);

        // 4: lui x5 held under back-pressure
        cyc();
        in_valid = 1'b1; inst = 32'h1234_52B7; pc = 32'h10C; out_ready = 1'b0;
        cyc();
        inst = 32'h0070_0313; pc = 32'h110;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("t4_op2",   op_2,           32'h1234_5000);
            chk("t4_wd",    32'(wd_addr),   32'd5);
            chk("t4_ready", 32'(in_ready),  32'd0);
            cyc();
        end
        out_ready = 1'b1;
        cyc(); in_valid = 1'b0;
        mid();
        chk("t4_next_op2", op_2, 32'd7);

        // 5: illegal opcode, then x17 which only RV32E rejects
        cyc();
        in_valid = 1'b1; inst = 32'hFFFF_FFFF; pc = 32'h114;
        cyc();
        inst = 32'h0020_88B3; pc = 32'h118;
        mid();
        chk("t5_ill",    32'(illegal),   32'd1);
        chk("t5_wen",    32'(reg_wen),   32'd0);
        chk("t5_e_ill",  32'(e_illegal), 32'd1);
        chk("t5_e_wen",  32'(e_reg_wen), 32'd0);
        cyc(); in_valid = 1'b0;
        mid();
        chk("t5_x17_ill",   32'(illegal),   32'd0);
        chk("t5_x17_wd",    32'(wd_addr),   32'd17);
        chk("t5_e_x17_ill", 32'(e_illegal), 32'd1);
        chk("t5_e_x17_wen", 32'(e_reg_wen), 32'd0);
        chk("t5_e_x17_wd",  32'(e_wd_addr), 32'd0);
        cyc();
        mid();
        chk("t5_e_idle_valid", 32'(e_out_valid), 32'd0);
        chk("t5_e_idle_hold",  32'(e_illegal),   32'd1);
        chk("t5_idle_zero",    32'(wd_addr),     32'd0);

        // 6: flush while holding a result and stalled, then reset mid-stream
        in_valid = 1'b1; inst = 32'h0050_0093; pc = 32'h11C; out_ready = 1'b0;
        cyc();
        flush = 1'b1; ex_load = 1'b1; inst = 32'h0020_81B3; pc = 32'h120;
        mid();
        chk("t6_ready_flush", 32'(in_ready), 32'd0);
        cyc(); flush = 1'b0;
        mid();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_stall", 32'(stall_cnt), 32'd3);
        cyc();
        ex_load = 1'b0; out_ready = 1'b1;
        mid();
        chk("t6_stall4",  32'(stall_cnt),   32'd4);
        chk("t6_e_sat",   32'(e_stall_cnt), 32'd3);
        cyc();
        mid();
        chk("t6_acc", 32'(out_valid), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        mid();
        chk("t6_rst_valid",   32'(out_valid),   32'd0);
        chk("t6_rst_stall",   32'(stall_cnt),   32'd0);
        chk("t6_rst_op1",     op_1,             32'd0);
        chk("t6_rst_e_stall", 32'(e_stall_cnt), 32'd0);
        chk("t6_rst_e_ill",   32'(e_illegal),   32'd0);
        cyc(); cyc();
        mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
